// File: rtl/ob_pkg.sv
// Order-book shared types: command bundle, opcodes and table-controller helpers.
// Imported by the conditional-table controller and its arbiter.
package ob_pkg;

  localparam int OB_CN_N_DEFAULT = 16;

  typedef enum logic [3:0] {
    Op_Nop           = 4'd0,
    Op_BuyMarket     = 4'd1,
    Op_BuyLimit      = 4'd2,
    Op_SellMarket    = 4'd3,
    Op_SellLimit     = 4'd4,
    Op_BuyStopLoss   = 4'd5,
    Op_BuyStopLimit  = 4'd6,
    Op_SellStopLoss  = 4'd7,
    Op_SellStopLimit = 4'd8,
    Op_Cancel        = 4'd9
  } opcode_t;

  typedef struct packed {
    opcode_t     op;
    logic [15:0] uid;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

  function automatic logic is_stop_op(input opcode_t op);
    case (op)
      Op_BuyStopLoss,
      Op_BuyStopLimit,
      Op_SellStopLoss,
      Op_SellStopLimit: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ob_cn_rr_arb.sv
// Round-robin one-hot arbiter: searches upward from ptr with wrap-around.
// Returns the pointer just past the winner so the next search starts there.
module ob_cn_rr_arb #(
  parameter int N  = 16,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr_nxt
);

  int            idx;
  logic [PW-1:0] sel;
  logic          hit;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    hit     = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (en && !hit && req[sel]) begin
        hit      = 1'b1;
        gnt[sel] = 1'b1;
        ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/ob_cn_table_ctrl.sv
// Conditional (stop-order) table controller: allocates stop commands to free
// entries and issues matured entries through a registered valid/ready stage.
module ob_cn_table_ctrl
  import ob_pkg::*;
#(
  parameter int N = OB_CN_N_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  input  cmd_t                   in_cmd,
  output logic                   in_rdy,
  output logic [N-1:0]           al_vld_r,
  output cmd_t                   al_cmd_r,
  input  logic [N-1:0]           busy_w,
  input  logic [N-1:0]           mtr_vld_w,
  input  logic [N-1:0]           cancel_hit,
  input  cmd_t                   ent_cmd_r [N],
  output logic [N-1:0]           dl_vld,
  output logic                   iss_vld_r,
  output cmd_t                   iss_cmd_r,
  input  logic                   iss_rdy,
  output logic                   full,
  output logic [$clog2(N+1)-1:0] occ,
  output logic                   err_r
);

  localparam int PW = $clog2(N);
  localparam int OW = $clog2(N + 1);

  logic [N-1:0]  busy_r;
  logic [N-1:0]  mtr_r;
  logic [N-1:0]  dl_prev_r;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  free;
  logic [N-1:0]  low_free;
  logic [N-1:0]  occ_vec;
  logic [N-1:0]  elig;
  logic [N-1:0]  gnt;
  logic          load;
  logic          accept;
  cmd_t          g_cmd;

  // A pending allocation is not yet visible in busy_r, so mask it here.
  assign free     = ~busy_r & ~al_vld_r;
  assign low_free = free & (~free + N'(1));
  assign in_rdy   = |free;
  assign full     = ~in_rdy;
  assign accept   = in_vld & in_rdy;
  assign occ_vec  = busy_r | al_vld_r;

  always_comb begin
    occ = '0;
    for (int k = 0; k < N; k++) occ = occ + OW'(occ_vec[k]);
  end

  assign elig = mtr_r & ~cancel_hit & ~dl_prev_r;
  assign load = (|elig) & (~iss_vld_r | iss_rdy);

  ob_cn_rr_arb #(.N(N), .PW(PW)) u_arb (
    .req     (elig),
    .ptr     (ptr_r),
    .en      (load),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  assign dl_vld = gnt;

  always_comb begin
    g_cmd = '0;
    for (int k = 0; k < N; k++)
      if (gnt[k]) g_cmd = ent_cmd_r[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= '0;
      mtr_r     <= '0;
      dl_prev_r <= '0;
      ptr_r     <= '0;
      al_vld_r  <= '0;
      al_cmd_r  <= '0;
      err_r     <= 1'b0;
      iss_vld_r <= 1'b0;
      iss_cmd_r <= '0;
    end else begin
      busy_r    <= busy_w;
      mtr_r     <= mtr_vld_w;
      dl_prev_r <= dl_vld;
      al_vld_r  <= '0;
      err_r     <= 1'b0;
      if (accept) begin
        if (is_stop_op(in_cmd.op)) begin
          al_vld_r <= low_free;
          al_cmd_r <= in_cmd;
        end else begin
          err_r <= 1'b1;
        end
      end
      if (load) begin
        iss_vld_r <= 1'b1;
        iss_cmd_r <= g_cmd;
        ptr_r     <= ptr_nxt;
      end else if (iss_rdy) begin
        iss_vld_r <= 1'b0;
      end
    end
  end

endmodule
